// File: rtl/shift_add_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_pkg
// Description : Shared types and helpers for the shift-and-add multiplier.
//               Provides the controller state encoding and a helper that
//               sizes the iteration counter from the operand width.
//               Optional feature macro used by this block:
//               SHIFT_ADD_MULT_EARLY_TERM_EN (stop once the multiplier
//               has no more set bits).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_mult_pkg;

    // Controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold every value 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : shift_add_mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult_dp.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_dp
// Description : Datapath of the shift-and-add multiplier. Holds the
//               accumulator, the zero-extended multiplicand and the
//               multiplier shift register, plus the adder and shifters.
//               Feature macro: SHIFT_ADD_MULT_EARLY_TERM_EN selects whether
//               o_last_iter also fires when the multiplier runs out of ones.
// Ports       : clk          - rising-edge clock
//               rst_n        - synchronous active-low reset
//               i_load       - load operands, clear accumulator
//               i_step       - perform one shift/add iteration
//               i_cnt_last   - controller is on its W-th iteration
//               i_a, i_b     - multiplicand / multiplier
//               o_acc_next   - accumulator value after this iteration's add
//               o_last_iter  - current iteration is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_dp #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_load,
    input  logic                      i_step,
    input  logic                      i_cnt_last,
    input  logic [DATA_WIDTH-1:0]     i_a,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic [2*DATA_WIDTH-1:0]   o_acc_next,
    output logic                      o_last_iter
);
    import shift_add_mult_pkg::*;

    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplr;

    // Add the shifted multiplicand only when the current multiplier LSB is set.
    always_comb begin
        o_acc_next = r_acc;
        if (r_mplr[0]) begin
            o_acc_next = r_acc + r_mcand;
        end
    end

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    // Once the bits above the LSB are all zero, the shifted multiplier is
    // zero after this iteration and no further additions can occur.
    assign o_last_iter = i_cnt_last || (r_mplr[DATA_WIDTH-1:1] == '0);
`else
    assign o_last_iter = i_cnt_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= {{DATA_WIDTH{1'b0}}, i_a};
            r_mplr  <= i_b;
        end else if (i_step) begin
            r_acc   <= o_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
        end
    end

endmodule : shift_add_mult_dp
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential unsigned multiplier, one multiplier bit per clock.
//               A one-cycle valid in IDLE starts an operation; done pulses
//               for one cycle when result takes the new product.
//               Feature macro: SHIFT_ADD_MULT_EARLY_TERM_EN ends the
//               operation as soon as the remaining multiplier bits are zero.
// Ports       : clk     - rising-edge clock
//               rst_n   - synchronous active-low reset
//               a, b    - unsigned operands, sampled on accepted valid
//               valid   - start request (one-cycle pulse)
//               done    - one-cycle completion pulse (registered)
//               result  - registered 2*DATA_WIDTH product, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic                      valid,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   result
);
    import shift_add_mult_pkg::*;

    localparam int               c_cnt_w = cnt_width(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_cnt_w-1:0]       r_cnt;
    logic                     r_done;
    logic [2*DATA_WIDTH-1:0]  r_result;

    logic                     w_load;
    logic                     w_step;
    logic                     w_finish;
    logic                     w_last_iter;
    logic [2*DATA_WIDTH-1:0]  w_acc_next;

    shift_add_mult_dp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_cnt_last  (r_cnt == c_cnt_last),
        .i_a         (a),
        .i_b         (b),
        .o_acc_next  (w_acc_next),
        .o_last_iter (w_last_iter)
    );

    // Next-state and control decode; valid only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_last_iter) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            // The final iteration's add is folded in via w_acc_next.
            r_done <= w_finish;
            if (w_finish) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule : shift_add_mult
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Self-checking bench for shift_add_mult (DATA_WIDTH=8).
//               Table of directed vectors plus hand-written sequences for
//               reset, ignored valid pulses and mid-operation reset.
//               Honours SHIFT_ADD_MULT_EARLY_TERM_EN for expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    localparam int c_w = 8;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [c_w-1:0]  a;
    logic [c_w-1:0]  b;
    logic            valid;
    logic            done;
    logic [2*c_w-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    shift_add_mult #(
        .DATA_WIDTH (c_w)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .valid  (valid),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          lat_def;
        int          lat_early;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a one-cycle valid sampled at the next rising edge (t0); returns
    // #1 after t0 with operands scrambled so late changes are exercised.
    task automatic start_op(input logic [7:0] xa, input logic [7:0] xb);
        @(negedge clk);
        a     = xa;
        b     = xb;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    // Count edges until done is seen; lat=-1 if it never appears. held is
    // cleared if result changes before done.
    task automatic wait_done(input int max_cyc, input logic [15:0] prev,
                             output int lat, output bit held);
        lat  = -1;
        held = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (result != prev) held = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        int          exp_lat;
        bit          held;
        logic [15:0] prev;

        vecs[0] = '{8'd15,  8'd11,  16'd165,   8, 4};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 8, 8};
        vecs[2] = '{8'd0,   8'd200, 16'd0,     8, 8};
        vecs[3] = '{8'd200, 8'd0,   16'd0,     8, 1};
        vecs[4] = '{8'd1,   8'd128, 16'd128,   8, 8};
        vecs[5] = '{8'd2,   8'd3,   16'd6,     8, 2};
        vecs[6] = '{8'd7,   8'd1,   16'd7,     8, 1};
        vecs[7] = '{8'd170, 8'd85,  16'd14450, 8, 7};
        vecs[8] = '{8'd128, 8'd255, 16'd32640, 8, 8};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        repeat (25) @(posedge clk);
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(5, 16'd0, lat, held);
        check("idle_no_done", lat, -1);

        // ---------------- table ----------------
        prev = 16'd0;
        foreach (vecs[i]) begin
            exp_lat = c_early ? vecs[i].lat_early : vecs[i].lat_def;
            start_op(vecs[i].a, vecs[i].b);
            wait_done(20, prev, lat, held);
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
            check($sformatf("vec%0d_result", i), result, vecs[i].prod);
            check($sformatf("vec%0d_old_held", i), held, 1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_fall", i), done, 0);
            check($sformatf("vec%0d_result_hold", i), result, vecs[i].prod);
            prev = vecs[i].prod;
        end

        // ------- valid during BUSY and during DONE is ignored -------
        start_op(8'd3, 8'd5);
        @(posedge clk);
        #1;
        a     = 8'd9;
        b     = 8'd9;
        valid = 1'b1;            // sampled at t0+2, still BUSY
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_done(20, prev, lat, held);
        check("busy_pulse_latency", lat, c_early ? 1 : 6);
        check("busy_pulse_result", result, 15);
        a     = 8'd9;
        b     = 8'd9;
        valid = 1'b1;            // sampled in DONE
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("done_pulse_fall", done, 0);
        wait_done(20, 16'd15, lat, held);
        check("no_second_done", lat, -1);
        check("result_kept_15", result, 15);

        // ---------------- reset mid-BUSY ----------------
        start_op(8'd255, 8'd255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;            // sampled at t0+4
        @(posedge clk);
        #1;
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(15, 16'd0, lat, held);
        check("abort_no_done", lat, -1);
        start_op(8'd2, 8'd3);
        wait_done(20, 16'd0, lat, held);
        check("after_abort_latency", lat, c_early ? 2 : 8);
        check("after_abort_result", result, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_shift_add_mult
`default_nettype wire
